// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with valid/ready handshake, synchronous flush and an
// optional second (skid) entry enabled by defining IF_ID_SKID_EN.
module if_id_skid_stage #(
  parameter int unsigned BUS_WIDTH   = 64,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BUS_WIDTH-1:0]   in_pc,
  input  logic [INSTR_WIDTH-1:0] in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BUS_WIDTH-1:0]   out_pc,
  output logic [INSTR_WIDTH-1:0] out_instr
);

  localparam logic [INSTR_WIDTH-1:0] NOP_W = INSTR_WIDTH'(NOP_INSTR);

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

  state_e                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   main_pc_q, main_pc_d;
  logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
`ifdef IF_ID_SKID_EN
  logic [BUS_WIDTH-1:0]   skid_pc_q, skid_pc_d;
  logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
`endif
  logic                   in_xfer, out_xfer;

  assign out_valid = (state_q != EMPTY);
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;

`ifdef IF_ID_SKID_EN
  // Ready comes from registered state only, cutting the decode->fetch comb path.
  assign in_ready = (state_q != SKID) & ~flush;
`else
  assign in_ready = (~out_valid | out_ready) & ~flush;
`endif

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
`ifdef IF_ID_SKID_EN
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
`endif
    if (flush) begin
      // Redirect: drop everything, show a NOP, keep the last PC for debug.
      state_d      = EMPTY;
      main_instr_d = NOP_W;
`ifdef IF_ID_SKID_EN
      skid_pc_d    = '0;
      skid_instr_d = '0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
            state_d      = FULL;
          end
        end
        FULL: begin
          if (in_xfer && out_xfer) begin
            main_pc_d    = in_pc;
            main_instr_d = in_instr;
          end else if (out_xfer) begin
            state_d = EMPTY;
`ifdef IF_ID_SKID_EN
          end else if (in_xfer) begin
            skid_pc_d    = in_pc;
            skid_instr_d = in_instr;
            state_d      = SKID;
`endif
          end
        end
`ifdef IF_ID_SKID_EN
        SKID: begin
          if (out_xfer) begin
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            state_d      = FULL;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      main_pc_q    <= '0;
      main_instr_q <= NOP_W;
`ifdef IF_ID_SKID_EN
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
`ifdef IF_ID_SKID_EN
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
`endif
    end
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage; the reference is an ordered queue
// of held entries plus the last displayed PC/instruction.
module tb_if_id_skid_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_instr, out_instr;
  logic [97:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef IF_ID_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  always #5 clk = ~clk;

  if_id_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  assign obs = {out_valid, out_pc, out_instr, in_ready};

  // Reference model: FIFO of held entries and what the outputs currently show.
  logic [63:0] q_pc[$];
  logic [31:0] q_in[$];
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] got[$];

  function automatic logic exp_ready();
    if (flush) return 1'b0;
    if (DEPTH == 2) return q_pc.size() < 2;
    return (q_pc.size() == 0) || out_ready;
  endfunction

  function automatic logic [97:0] exp_vec();
    return {q_pc.size() != 0, m_pc, m_instr, exp_ready()};
  endfunction

  task automatic model_reset();
    q_pc.delete(); q_in.delete();
    m_pc = '0; m_instr = NOP;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic r, input logic f);
    in_valid = v; in_pc = pc; in_instr = pc[31:0] ^ 32'hA5A5_0000;
    out_ready = r; flush = f;
    #1;
  endtask

  // Advance one clock edge and update the model from the inputs seen at the edge.
  task automatic tick();
    logic ix, ox;
    ix = in_valid & exp_ready();
    ox = (q_pc.size() != 0) & out_ready;
    if (ox) got.push_back(q_pc[0]);
    @(posedge clk);
    if (flush) begin
      q_pc.delete(); q_in.delete();
      m_instr = NOP;
    end else begin
      if (ox) begin void'(q_pc.pop_front()); void'(q_in.pop_front()); end
      if (ix) begin q_pc.push_back(in_pc); q_in.push_back(in_instr); end
      if (q_pc.size() != 0) begin m_pc = q_pc[0]; m_instr = q_in[0]; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, '0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== NOP || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got v=%b pc=%h i=%h r=%b exp v=0 pc=0 i=%h r=1",
               out_valid, out_pc, out_instr, in_ready, NOP);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      drive(i < 3, 64'h1000 + 64'(4 * i), 1, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL stream_pre[%0d] got %h exp %h", i, obs, exp_vec());
      end
      tick();
      if (i < 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h1000 + 64'(4 * i)) begin
          errors++;
          $display("FAIL stream_out[%0d] got v=%b pc=%h exp v=1 pc=%h", i, out_valid, out_pc,
                   64'h1000 + 64'(4 * i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pcs[3];
    int idx = 0;
    pcs[0] = 64'h2000; pcs[1] = 64'h2004; pcs[2] = 64'h2008;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      drive(idx < 3, pcs[idx < 3 ? idx : 2], c >= 4, 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL backpressure[%0d] got %h exp %h", c, obs, exp_vec());
      end
      if (DEPTH == 2 && c == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_skid_ready got %b exp 0", in_ready);
        end
      end
      if (in_valid && exp_ready()) idx++;
      tick();
    end
    checks++;
    if (got.size() != 3 || got[0] !== 64'h2000 || got[1] !== 64'h2004 || got[2] !== 64'h2008) begin
      errors++;
      $display("FAIL bp_order got n=%0d first=%h exp 2000,2004,2008", got.size(),
               got.size() ? got[0] : 64'hx);
    end
  endtask

  task automatic test_flush_skid();
    drive(1, 64'h3000, 0, 0); tick();
    drive(1, 64'h3004, 0, 0); tick();
    drive(0, '0, 0, 1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %b exp 0", in_ready);
    end
    tick();
    drive(0, '0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h3000) begin
      errors++;
      $display("FAIL flush_out got v=%b pc=%h i=%h exp v=0 pc=3000 i=%h",
               out_valid, out_pc, out_instr, NOP);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || obs !== exp_vec()) begin
        errors++; $display("FAIL flush_drain[%0d] got %h exp %h", c, obs, exp_vec());
      end
    end
  endtask

  task automatic test_flush_in();
    drive(1, 64'h4000, 1, 1);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready);
    end
    tick();
    drive(0, '0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_pc === 64'h4000 || obs !== exp_vec()) begin
      errors++; $display("FAIL flush_in_capture got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    drive(1, 64'h5000, 0, 0); tick();
    drive(1, 64'h5004, 0, 0); tick();
    drive(0, '0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 64'h0) begin
      errors++;
      $display("FAIL async_reset got v=%b pc=%h i=%h exp v=0 pc=0 i=%h",
               out_valid, out_pc, out_instr, NOP);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL async_release got %h exp %h", obs, exp_vec());
    end
  endtask

  task automatic test_comb_ready();
    got.delete();
    drive(1, 64'h6000, 1, 0); tick();
    drive(1, 64'h6004, 0, 0);
    checks++;
    if (in_ready !== (DEPTH == 2) || obs !== exp_vec()) begin
      errors++; $display("FAIL comb_ready_lo got %h exp %h", obs, exp_vec());
    end
    drive(1, 64'h6004, 1, 0);
    checks++;
    if (in_ready !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL comb_ready_hi got %h exp %h", obs, exp_vec());
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, '0, 1, 0);
      tick();
    end
    checks++;
    if (got.size() != 2 || got[0] !== 64'h6000 || got[1] !== 64'h6004) begin
      errors++; $display("FAIL comb_no_loss got n=%0d exp 2 (6000,6004)", got.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 3) != 0, {32'h0, $urandom} & 64'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_pre[%0d] got %h exp %h", c, obs, exp_vec());
      end
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_post[%0d] got %h exp %h", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_skid();
    test_flush_in();
    test_async_reset();
    test_comb_ready();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
